pp_pipeline_accel_hls_deadlock_report_ctrl: RTL and testbench
=============================================================

// Module: pp_pipeline_accel_hls_deadlock_report_ctrl
// PURPOSE
//   Central controller on the far side of the per-process deadlock detect units.
//   Collects every unit's dl_detect_out and confirms a persistent detection.
//   Elects one origin process, drives the dl_detect_in broadcast, and injects/clears the trace token.
//   Records which processes the token visited and reports the deadlock cycle to the host until acknowledged.
// PARAMETERS
//   PROC_NUM        4   number of dataflow processes / detect units (>=2)
//   CONFIRM_CYCLES  16  consecutive cycles origin dl_detect must hold before tracing (>=1)
//   TRACE_LIMIT     16  max TRACE cycles before abandoning the trace (>=PROC_NUM+1)
// PORTS
//   clock            in   1         rising-edge clock
//   reset            in   1         asynchronous reset, active-high
//   dl_detect_vec    in   PROC_NUM  bit p = dl_detect_out of detect unit p
//   token_vec        in   PROC_NUM  bit p = OR of token_in_vec of unit p
//   ack              in   1         host acknowledge; clears a report
//   dl_detect_bcast  out  1         dl_detect_in driven to all units
//   origin_vec       out  PROC_NUM  one-hot origin pulse to unit origin input
//   token_clear_vec  out  PROC_NUM  one-hot token_clear to units
//   dl_found         out  1         deadlock report valid
//   dl_proc_mask     out  PROC_NUM  processes in the deadlock cycle
//   dl_origin_id     out  $clog2(PROC_NUM)  index of elected origin
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; all outputs 0; counters and mask 0.
//   All outputs are registered except token_clear_vec (combinational, see TRACE).
//   FSM states: IDLE, CONFIRM, TRACE, REPORT.
//   IDLE:
//     - |dl_detect_vec -> CONFIRM; origin = lowest set index; dl_origin_id <= origin; cnt <= 0.
//   CONFIRM:
//     - dl_detect_vec[origin]==0 -> IDLE; dl_origin_id <= 0.
//     - else cnt++; when cnt==CONFIRM_CYCLES-1 -> TRACE.
//     - On that transition: dl_detect_bcast<=1; origin_vec<=1<<origin for exactly 1 cycle;
//       dl_proc_mask<=1<<origin; tcnt<=0.
//     - Other units' detect bits are ignored; the origin is never re-elected while in CONFIRM.
//   TRACE:
//     - dl_proc_mask <= dl_proc_mask | token_vec every cycle.
//     - token_vec[origin]==1 and tcnt>=1: token has returned.
//       * token_clear_vec = 1<<origin in the same cycle (combinational).
//       * Next state REPORT; dl_found<=1.
//       * dl_proc_mask is captured including that cycle's token_vec.
//     - Otherwise tcnt++; tcnt==TRACE_LIMIT-1 -> IDLE.
//       * Timeout exit: dl_detect_bcast<=0; dl_proc_mask<=0; dl_origin_id<=0; no report.
//     - token_vec[origin] in the cycle origin_vec is high (tcnt==0) is not a return.
//   REPORT:
//     - dl_found, dl_proc_mask, dl_origin_id and dl_detect_bcast=1 are held stable.
//     - ack -> IDLE; next cycle all outputs 0.
//     - ack in any other state has no effect.
//     - Token/detect activity in REPORT is ignored and does not change the mask.
//   Width rules:
//     - cnt width $clog2(CONFIRM_CYCLES+1) and tcnt width $clog2(TRACE_LIMIT+1); neither wraps.
//     - CONFIRM_CYCLES==1: CONFIRM lasts one cycle.
//   Simultaneous events:
//     - Detect loss and terminal count in the same CONFIRM cycle -> IDLE (loss wins).
//     - Token return and TRACE timeout in the same cycle -> REPORT (return wins).
//   Invariant: origin_vec and token_clear_vec are one-hot or zero and never asserted together.
// TESTING (PROC_NUM=4, CONFIRM_CYCLES=4, TRACE_LIMIT=8)
//   1. Reset mid-TRACE -> all outputs 0 asynchronously; the first cycle after release is IDLE.
//   2. dl_detect_vec=4'b0110 held -> origin=1; origin_vec=4'b0010 pulses 4 cycles after entry
//      with dl_detect_bcast=1.
//   3. Full trace: origin 1, then token_vec 4'b0100, 4'b1000, 4'b0010 on successive cycles
//      -> token_clear_vec=4'b0010 on the return cycle.
//      Next cycle: dl_found=1, dl_proc_mask=4'b1110, dl_origin_id=1.
//   4. dl_detect_vec[1] drops on CONFIRM cycle 2 -> back to IDLE; origin_vec never pulses.
//   5. TRACE with no token return for 8 cycles -> IDLE, dl_detect_bcast=0, dl_found stays 0.
//   6. In REPORT with token_vec=4'b1111 toggling -> mask unchanged.
//      ack=1 -> all outputs 0 the next cycle.
//      ack=1 pulsed while in IDLE -> no effect.

Source files
------------

// File: rtl/pp_pipeline_accel_hls_deadlock_report_ctrl.sv
// Deadlock report controller: confirms a persistent detect, elects an origin, runs the
// token trace and holds the resulting process mask for the host until acknowledged.
module pp_pipeline_accel_hls_deadlock_report_ctrl #(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned TRACE_LIMIT    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PROC_NUM-1:0]         dl_detect_vec,
  input  logic [PROC_NUM-1:0]         token_vec,
  input  logic                        ack,
  output logic                        dl_detect_bcast,
  output logic [PROC_NUM-1:0]         origin_vec,
  output logic [PROC_NUM-1:0]         token_clear_vec,
  output logic                        dl_found,
  output logic [PROC_NUM-1:0]         dl_proc_mask,
  output logic [$clog2(PROC_NUM)-1:0] dl_origin_id
);

  localparam int unsigned OriginW = $clog2(PROC_NUM);
  localparam int unsigned CntW    = $clog2(CONFIRM_CYCLES + 1);
  localparam int unsigned TcntW   = $clog2(TRACE_LIMIT + 1);

  localparam logic [PROC_NUM-1:0] OneHotLsb = PROC_NUM'(1);
  localparam logic [CntW-1:0]     CntLast   = CntW'(CONFIRM_CYCLES - 1);
  localparam logic [TcntW-1:0]    TcntLast  = TcntW'(TRACE_LIMIT - 1);

  typedef enum logic [1:0] {StIdle, StConfirm, StTrace, StReport} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [TcntW-1:0]   tcnt_q;
  logic [OriginW-1:0] lowest_idx;
  logic [PROC_NUM-1:0] origin_onehot;
  logic               token_return;

  // Lowest-index election: scan downwards so the last hit wins.
  always_comb begin
    lowest_idx = '0;
    for (int i = int'(PROC_NUM) - 1; i >= 0; i--) begin
      if (dl_detect_vec[i]) lowest_idx = OriginW'(i);
    end
  end

  // dl_origin_id doubles as the origin register while a detection is in flight.
  assign origin_onehot   = OneHotLsb << dl_origin_id;
  assign token_return    = (state_q == StTrace) && (tcnt_q != '0) && token_vec[dl_origin_id];
  assign token_clear_vec = token_return ? origin_onehot : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      tcnt_q          <= '0;
      dl_detect_bcast <= 1'b0;
      origin_vec      <= '0;
      dl_found        <= 1'b0;
      dl_proc_mask    <= '0;
      dl_origin_id    <= '0;
    end else begin
      origin_vec <= '0;
      unique case (state_q)
        StIdle: begin
          if (|dl_detect_vec) begin
            state_q      <= StConfirm;
            dl_origin_id <= lowest_idx;
            cnt_q        <= '0;
          end
        end
        StConfirm: begin
          // Losing the origin's detect beats reaching the terminal count.
          if (!dl_detect_vec[dl_origin_id]) begin
            state_q      <= StIdle;
            dl_origin_id <= '0;
          end else if (cnt_q == CntLast) begin
            state_q         <= StTrace;
            dl_detect_bcast <= 1'b1;
            origin_vec      <= origin_onehot;
            dl_proc_mask    <= origin_onehot;
            tcnt_q          <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StTrace: begin
          // A return on the final trace cycle still produces a report.
          if (token_return) begin
            state_q      <= StReport;
            dl_found     <= 1'b1;
            dl_proc_mask <= dl_proc_mask | token_vec;
          end else if (tcnt_q == TcntLast) begin
            state_q         <= StIdle;
            dl_detect_bcast <= 1'b0;
            dl_proc_mask    <= '0;
            dl_origin_id    <= '0;
          end else begin
            tcnt_q       <= tcnt_q + TcntW'(1);
            dl_proc_mask <= dl_proc_mask | token_vec;
          end
        end
        StReport: begin
          if (ack) begin
            state_q         <= StIdle;
            dl_detect_bcast <= 1'b0;
            dl_found        <= 1'b0;
            dl_proc_mask    <= '0;
            dl_origin_id    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_hls_deadlock_report_ctrl.sv
// Scoreboard bench: a transaction-level model predicts events per scenario; a negedge
// monitor pops and compares whenever the controller emits a pulse, edge or report.
module tb_pp_pipeline_accel_hls_deadlock_report_ctrl;

  localparam int P = 4;
  localparam int C = 4;
  localparam int L = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [P-1:0] dl_detect_vec = '0;
  logic [P-1:0] token_vec = '0;
  logic         ack = 1'b0;
  logic         dl_detect_bcast;
  logic [P-1:0] origin_vec;
  logic [P-1:0] token_clear_vec;
  logic         dl_found;
  logic [P-1:0] dl_proc_mask;
  logic [1:0]   dl_origin_id;

  pp_pipeline_accel_hls_deadlock_report_ctrl #(
    .PROC_NUM      (P),
    .CONFIRM_CYCLES(C),
    .TRACE_LIMIT   (L)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dl_detect_vec  (dl_detect_vec),
    .token_vec      (token_vec),
    .ack            (ack),
    .dl_detect_bcast(dl_detect_bcast),
    .origin_vec     (origin_vec),
    .token_clear_vec(token_clear_vec),
    .dl_found       (dl_found),
    .dl_proc_mask   (dl_proc_mask),
    .dl_origin_id   (dl_origin_id)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [P-1:0] vec;
    int           id;
  } ev_t;

  ev_t q_origin[$];
  ev_t q_clear[$];
  ev_t q_brise[$];
  ev_t q_bfall[$];
  ev_t q_report[$];
  int  q_zero[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [P-1:0] tok_buf[L];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor
  logic         prev_bcast = 1'b0;
  logic         prev_found = 1'b0;
  logic [P-1:0] hold_mask = '0;
  int           hold_id = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      ev_t e;
      if (origin_vec != '0) begin
        if (q_origin.size() == 0) unexpected("origin_pulse");
        else begin
          e = q_origin.pop_front();
          check("origin_cycle", cyc, e.cyc);
          check("origin_vec", origin_vec, e.vec);
        end
      end
      if (token_clear_vec != '0) begin
        if (q_clear.size() == 0) unexpected("token_clear");
        else begin
          e = q_clear.pop_front();
          check("clear_cycle", cyc, e.cyc);
          check("token_clear_vec", token_clear_vec, e.vec);
        end
        check("pulse_overlap", origin_vec & token_clear_vec, 0);
      end
      if (dl_detect_bcast && !prev_bcast) begin
        if (q_brise.size() == 0) unexpected("bcast_rise");
        else begin
          e = q_brise.pop_front();
          check("bcast_rise_cycle", cyc, e.cyc);
          check("bcast_origin_id", dl_origin_id, e.id);
        end
      end
      if (!dl_detect_bcast && prev_bcast) begin
        if (q_bfall.size() == 0) unexpected("bcast_fall");
        else begin
          e = q_bfall.pop_front();
          check("bcast_fall_cycle", cyc, e.cyc);
        end
      end
      if (dl_found && !prev_found) begin
        if (q_report.size() == 0) unexpected("report");
        else begin
          e = q_report.pop_front();
          hold_mask = e.vec;
          hold_id = e.id;
          check("report_cycle", cyc, e.cyc);
          check("report_mask", dl_proc_mask, e.vec);
          check("report_origin_id", dl_origin_id, e.id);
        end
      end else if (dl_found && prev_found) begin
        check("report_hold", {dl_detect_bcast, dl_proc_mask, dl_origin_id},
              {1'b1, hold_mask, 2'(hold_id)});
      end
      if (q_zero.size() != 0 && q_zero[0] <= cyc) begin
        check("zero_cycle", cyc, q_zero[0]);
        void'(q_zero.pop_front());
        check("outputs_zero", {dl_detect_bcast, origin_vec, token_clear_vec, dl_found,
                               dl_proc_mask, dl_origin_id}, 0);
      end
      prev_bcast = dl_detect_bcast;
      prev_found = dl_found;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [P-1:0] d, input logic [P-1:0] t, input logic a);
    dl_detect_vec = d;
    token_vec = t;
    ack = a;
  endtask

  function automatic int lowest(input logic [P-1:0] v);
    for (int i = 0; i < P; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic ev_t mk(input int c, input logic [P-1:0] v, input int id);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    e.id = id;
    return e;
  endfunction

  // One detection episode. drop_at>0 clears detect on that CONFIRM cycle (1..C).
  task automatic scenario(input logic [P-1:0] det0, input int drop_at, input int rep_hold,
                          input bit use_buf);
    int s, org, r, t0, a, last_j;
    logic [P-1:0] toks[L];
    logic [P-1:0] oh, m;
    next_cycle();
    s = cyc;
    org = lowest(det0);
    oh = 4'b0001 << org;
    for (int j = 0; j < L; j++) begin
      if (use_buf) toks[j] = tok_buf[j];
      else begin
        toks[j] = 4'($urandom);
        if (j >= 1 && $urandom_range(0, 2) != 0) toks[j] = toks[j] & ~oh;
      end
    end
    if (drop_at > 0) begin
      q_zero.push_back(s + drop_at + 1);
      drive(det0, '0, 1'b0);
      for (int k = 1; k < drop_at; k++) begin
        next_cycle();
        drive(4'($urandom) | oh, '0, 1'b0);
      end
      next_cycle();
      drive('0, '0, 1'b0);
      repeat (2) next_cycle();
      return;
    end
    t0 = s + 1 + C;
    q_brise.push_back(mk(t0, '0, org));
    q_origin.push_back(mk(t0, oh, org));
    r = 0;
    for (int j = 1; j < L; j++) if (r == 0 && toks[j][org]) r = j;
    if (r > 0) begin
      m = oh;
      for (int j = 0; j <= r; j++) m = m | toks[j];
      a = t0 + r + 1 + rep_hold;
      q_clear.push_back(mk(t0 + r, oh, org));
      q_report.push_back(mk(t0 + r + 1, m, org));
      q_bfall.push_back(mk(a + 1, '0, 0));
      q_zero.push_back(a + 1);
      last_j = r;
    end else begin
      q_bfall.push_back(mk(t0 + L, '0, 0));
      q_zero.push_back(t0 + L);
      last_j = L - 1;
    end
    drive(det0, '0, 1'b0);
    for (int k = 1; k <= C; k++) begin
      next_cycle();
      drive(4'($urandom) | oh, '0, 1'b0);
    end
    for (int j = 0; j <= last_j; j++) begin
      next_cycle();
      drive(4'($urandom), toks[j], 1'b0);
    end
    if (r > 0) begin
      for (int h = 0; h < rep_hold; h++) begin
        next_cycle();
        drive(4'($urandom), (h % 2 == 0) ? 4'hf : 4'($urandom), 1'b0);
      end
      next_cycle();
      drive('0, 4'hf, 1'b1);
    end
    next_cycle();
    drive('0, '0, 1'b0);
    next_cycle();
  endtask

  initial begin
    int s;
    #2;
    check("reset_outputs", {dl_detect_bcast, origin_vec, token_clear_vec, dl_found,
                            dl_proc_mask, dl_origin_id}, 0);
    #10 reset = 1'b0;
    mon_en = 1'b1;

    // ack while idle does nothing
    next_cycle();
    drive('0, '0, 1'b1);
    q_zero.push_back(cyc);
    q_zero.push_back(cyc + 1);
    next_cycle();
    drive('0, '0, 1'b0);

    // Full trace from origin 1, mask 1110, report held while tokens toggle
    for (int j = 0; j < L; j++) tok_buf[j] = '0;
    tok_buf[1] = 4'b0100;
    tok_buf[2] = 4'b1000;
    tok_buf[3] = 4'b0010;
    scenario(4'b0110, 0, 3, 1'b1);

    // Origin detect lost on CONFIRM cycle 2, and on the terminal CONFIRM cycle
    scenario(4'b0010, 2, 0, 1'b0);
    scenario(4'b1100, C, 0, 1'b0);

    // No return: timeout
    for (int j = 0; j < L; j++) tok_buf[j] = 4'b1110;
    scenario(4'b0001, 0, 0, 1'b1);

    // Origin token on tcnt 0 ignored; return on the final trace cycle wins
    for (int j = 0; j < L; j++) tok_buf[j] = 4'b0001;
    tok_buf[0] = 4'b1000;
    tok_buf[L-1] = 4'b1000;
    scenario(4'b1000, 0, 1, 1'b1);

    // Reset asserted mid-TRACE
    next_cycle();
    s = cyc;
    q_brise.push_back(mk(s + 1 + C, '0, 2));
    q_origin.push_back(mk(s + 1 + C, 4'b0100, 2));
    drive(4'b0100, '0, 1'b0);
    for (int k = 1; k <= C; k++) begin
      next_cycle();
      drive(4'b0100, '0, 1'b0);
    end
    repeat (2) begin
      next_cycle();
      drive('0, 4'b0011, 1'b0);
    end
    next_cycle();
    q_bfall.push_back(mk(cyc, '0, 0));
    q_zero.push_back(cyc);
    #2 reset = 1'b1;
    #1;
    check("reset_async", {dl_detect_bcast, origin_vec, token_clear_vec, dl_found,
                          dl_proc_mask, dl_origin_id}, 0);
    next_cycle();
    drive('0, '0, 1'b0);
    #2 reset = 1'b0;
    scenario(4'b1010, 0, 0, 1'b0);

    // Random episodes
    for (int n = 0; n < 40; n++) begin
      logic [P-1:0] d;
      d = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) scenario(d, $urandom_range(1, C), 0, 1'b0);
      else scenario(d, 0, $urandom_range(0, 3), 1'b0);
    end

    repeat (4) next_cycle();
    check("leftover_events", q_origin.size() + q_clear.size() + q_brise.size() +
          q_bfall.size() + q_report.size() + q_zero.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
